// File: rtl/irq_request_gen.sv
// -----------------------------------------------------------------------------
// irq_request_gen
// Source end of the button-interrupt protocol. Four raw push-button lines are
// synchronized, debounced and edge-detected into pending requests. A small
// FSM presents one request code at a time toward the interrupt controller and
// follows the controller's on_interrupt status until the handler returns.
//
// Optional feature: define IRQ_MASK_EN to add the irq_mask input. Masked keys
// still debounce and latch pending bits but are skipped by arbitration.
// -----------------------------------------------------------------------------
module irq_request_gen #(
   parameter int DEBOUNCE_CYCLES = 4,   // stable cycles before a level is accepted (>=2)
   parameter int REQ_TIMEOUT     = 16   // cycles a request waits before withdrawal (>=2)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] keys_in,
   input  logic [1:0] on_interrupt,
`ifdef IRQ_MASK_EN
   input  logic [3:0] irq_mask,
`endif
   output logic [3:0] irq_code,
   output logic [3:0] pending,
   output logic       busy,
   output logic [7:0] drop_count
);

   localparam int DCW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TCW = (REQ_TIMEOUT > 2) ? $clog2(REQ_TIMEOUT) : 1;
   localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TCW-1:0] TMO_LAST = TCW'(REQ_TIMEOUT - 1);

   // Controller status encodings seen on on_interrupt
   localparam logic [1:0] ON_IDLE      = 2'b00;
   localparam logic [1:0] ON_RETURNING = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQUEST,
      ST_SERVICE,
      ST_RETURN
   } state_t;

   // ---------------------------------------------------------------------------
   // Key conditioning state
   // ---------------------------------------------------------------------------
   logic [3:0]     sync1_q;
   logic [3:0]     sync2_q;
   logic [3:0]     deb_q;
   logic [3:0]     deb_d;
   logic [DCW-1:0] deb_cnt_q [4];
   logic [DCW-1:0] deb_cnt_d [4];
   logic [3:0]     deb_rise;
   logic [3:0]     pending_q;
   logic [3:0]     pending_d;

   // ---------------------------------------------------------------------------
   // Request FSM state
   // ---------------------------------------------------------------------------
   state_t         state_q;
   logic [1:0]     sel_q;        // key currently being requested/serviced
   logic [3:0]     irq_code_q;
   logic [TCW-1:0] tmo_q;
   logic [7:0]     drop_q;

   logic [3:0]     eligible;
   logic [1:0]     win_idx;
   logic [3:0]     grant_clr;

   // Debounce: a key's accepted level only follows the synchronized level
   // after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
   always_comb begin
      // NOTE: every combinational output gets a default first so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      deb_d     = deb_q;
      deb_cnt_d = deb_cnt_q;
      for (int k = 0; k < 4; k++) begin
         if (sync2_q[k] == deb_q[k]) begin
            deb_cnt_d[k] = '0;
         end else if (deb_cnt_q[k] == DEB_LAST) begin
            deb_d[k]     = sync2_q[k];
            deb_cnt_d[k] = '0;
         end else begin
            deb_cnt_d[k] = deb_cnt_q[k] + DCW'(1);
         end
      end
   end

   // Only a 0->1 transition of the accepted level raises a request.
   assign deb_rise = deb_d & ~deb_q;

   // Arbitration pool: pending keys, optionally minus masked ones.
`ifdef IRQ_MASK_EN
   assign eligible = pending_q & ~irq_mask;
`else
   assign eligible = pending_q;
`endif

   // Fixed priority: lowest key index wins.
   always_comb begin
      win_idx = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (eligible[k]) begin
            win_idx = 2'(k);
         end
      end
   end

   // The serviced key's pending bit is released on the grant edge.
   assign grant_clr = ((state_q == ST_REQUEST) && (on_interrupt != ON_IDLE))
                      ? (4'b0001 << sel_q) : 4'b0000;

   // A new rise on the same edge as the grant survives: set wins over clear.
   assign pending_d = (pending_q & ~grant_clr) | deb_rise;

   // Key conditioning registers: synchronizers, debouncers, pending latches.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         deb_cnt_q <= '{default: '0};
         pending_q <= '0;
      end else begin
         sync1_q   <= keys_in;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_cnt_q <= deb_cnt_d;
         pending_q <= pending_d;
      end
   end

   // Request FSM with registered request code, timeout and drop counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sel_q      <= 2'd0;
         irq_code_q <= 4'd0;
         tmo_q      <= '0;
         drop_q     <= 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|eligible) begin
                  sel_q      <= win_idx;
                  irq_code_q <= {2'b00, win_idx} + 4'd1;
                  tmo_q      <= '0;
                  state_q    <= ST_REQUEST;
               end
            end
            ST_REQUEST: begin
               if (on_interrupt != ON_IDLE) begin
                  irq_code_q <= 4'd0;
                  state_q    <= ST_SERVICE;
               end else if (tmo_q == TMO_LAST) begin
                  // Withdraw; the pending bit stays so it is re-arbitrated.
                  irq_code_q <= 4'd0;
                  state_q    <= ST_IDLE;
                  if (drop_q != 8'hFF) begin
                     drop_q <= drop_q + 8'd1;
                  end
               end else begin
                  tmo_q <= tmo_q + TCW'(1);
               end
            end
            ST_SERVICE: begin
               if (on_interrupt == ON_RETURNING) begin
                  state_q <= ST_RETURN;
               end else if (on_interrupt == ON_IDLE) begin
                  state_q <= ST_IDLE;   // controller aborted the entry
               end
            end
            ST_RETURN: begin
               if (on_interrupt == ON_IDLE) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign irq_code   = irq_code_q;
   assign pending    = pending_q;
   assign busy       = (state_q != ST_IDLE);
   assign drop_count = drop_q;

   // A non-zero code is presented exactly while a request is outstanding.
   a_code_only_in_request : assert property (
      @(posedge clock) disable iff (reset)
      (irq_code_q != 4'd0) == (state_q == ST_REQUEST));

   // Codes are limited to the four key encodings.
   a_code_range : assert property (
      @(posedge clock) disable iff (reset)
      irq_code_q <= 4'd4);

endmodule

// File: tb/tb_irq_request_gen.sv
// -----------------------------------------------------------------------------
// tb_irq_request_gen
// Directed scenarios with fixed expected values, followed by a randomized run
// compared against a behavioural model of the key/request protocol.
// -----------------------------------------------------------------------------
module tb_irq_request_gen;

   localparam int DEB = 4;
   localparam int TMO = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] keys_in = 4'd0;
   logic [1:0] on_interrupt = 2'd0;
   logic [3:0] irq_mask = 4'd0;
   logic [3:0] irq_code;
   logic [3:0] pending;
   logic       busy;
   logic [7:0] drop_count;

   int n_vec = 0;
   int n_bad = 0;

   irq_request_gen #(.DEBOUNCE_CYCLES(DEB), .REQ_TIMEOUT(TMO)) dut (
      .clock        (clock),
      .reset        (reset),
      .keys_in      (keys_in),
      .on_interrupt (on_interrupt),
`ifdef IRQ_MASK_EN
      .irq_mask     (irq_mask),
`endif
      .irq_code     (irq_code),
      .pending      (pending),
      .busy         (busy),
      .drop_count   (drop_count)
   );

   always #5 clock = ~clock;

   // ---------------------------------------------------------------------------
   // Behavioural model: levels, run lengths of disagreement, and a phase
   // number for where the handshake is.
   // ---------------------------------------------------------------------------
   bit [3:0] m_s1, m_s2, m_deb, m_pend, m_code;
   int       m_run [4];
   int       m_phase;   // 0 idle, 1 requesting, 2 in service, 3 returning
   int       m_idx, m_wait, m_drops;

   task automatic model_step();
      bit [3:0] rise, clr, elig, mask;
`ifdef IRQ_MASK_EN
      mask = irq_mask;
`else
      mask = 4'd0;
`endif
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_deb = 0; m_pend = 0; m_code = 0;
         for (int k = 0; k < 4; k++) m_run[k] = 0;
         m_phase = 0; m_idx = 0; m_wait = 0; m_drops = 0;
         return;
      end
      rise = 0;
      clr  = 0;
      for (int k = 0; k < 4; k++) begin
         if (m_s2[k] != m_deb[k]) begin
            m_run[k]++;
            if (m_run[k] == DEB) begin
               m_deb[k] = m_s2[k];
               m_run[k] = 0;
               rise[k]  = m_deb[k];
            end
         end else begin
            m_run[k] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = keys_in;
      case (m_phase)
         0: begin
            elig = m_pend & ~mask;
            if (elig != 0) begin
               for (int k = 3; k >= 0; k--) if (elig[k]) m_idx = k;
               m_code  = 4'(m_idx + 1);
               m_wait  = 0;
               m_phase = 1;
            end
         end
         1: begin
            if (on_interrupt != 2'd0) begin
               m_phase    = 2;
               m_code     = 0;
               clr[m_idx] = 1'b1;
            end else if (m_wait == TMO - 1) begin
               m_phase = 0;
               m_code  = 0;
               if (m_drops < 255) m_drops++;
            end else begin
               m_wait++;
            end
         end
         2: begin
            if (on_interrupt == 2'd2) m_phase = 3;
            else if (on_interrupt == 2'd0) m_phase = 0;
         end
         default: begin
            if (on_interrupt == 2'd0) m_phase = 0;
         end
      endcase
      m_pend = (m_pend & ~clr) | rise;
   endtask

   // One clock: the model consumes the inputs seen at the rising edge, and
   // control returns on the falling edge, where outputs are sampled.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         model_step();
         @(negedge clock);
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1; keys_in = 0; on_interrupt = 0;
      tick(2);
      reset = 1'b0;
      n_vec++; if (irq_code !== 4'd0) begin n_bad++; $display("FAIL reset_code: got %0d want 0", irq_code); end
      n_vec++; if (pending !== 4'd0) begin n_bad++; $display("FAIL reset_pending: got %b want 0000", pending); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL reset_drops: got %0d want 0", drop_count); end
   endtask

   task automatic test_basic();
      keys_in = 4'b0001;
      tick(5);
      n_vec++; if (pending !== 4'd0) begin n_bad++; $display("FAIL basic_pend_early: got %b want 0000", pending); end
      tick();
      n_vec++; if (pending !== 4'b0001) begin n_bad++; $display("FAIL basic_pend: got %b want 0001", pending); end
      n_vec++; if (irq_code !== 4'd0) begin n_bad++; $display("FAIL basic_code_early: got %0d want 0", irq_code); end
      tick();
      n_vec++; if (irq_code !== 4'd1) begin n_bad++; $display("FAIL basic_code: got %0d want 1", irq_code); end
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
      on_interrupt = 2'b11; tick();
      n_vec++; if (irq_code !== 4'd0) begin n_bad++; $display("FAIL basic_grant_code: got %0d want 0", irq_code); end
      n_vec++; if (pending !== 4'd0) begin n_bad++; $display("FAIL basic_grant_pend: got %b want 0000", pending); end
      on_interrupt = 2'b01; tick();
      on_interrupt = 2'b10; tick();
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_return_busy: got %b want 1", busy); end
      on_interrupt = 2'b00; tick();
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
      keys_in = 4'b0000; tick(8);
      n_vec++; if (irq_code !== 4'd0 || pending !== 4'd0) begin
         n_bad++; $display("FAIL basic_release: got code %0d pend %b want 0 0000", irq_code, pending);
      end
   endtask

   task automatic test_glitch();
      keys_in = 4'b0010; tick(3);
      keys_in = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_vec++; if (pending !== 4'd0 || irq_code !== 4'd0) begin
            n_bad++; $display("FAIL glitch: got pend %b code %0d want 0000 0", pending, irq_code);
         end
      end
   endtask

   task automatic test_priority();
      keys_in = 4'b0110; tick(6);
      n_vec++; if (pending !== 4'b0110) begin n_bad++; $display("FAIL prio_pend: got %b want 0110", pending); end
      tick();
      n_vec++; if (irq_code !== 4'd2) begin n_bad++; $display("FAIL prio_first: got %0d want 2", irq_code); end
      on_interrupt = 2'b11; tick();
      n_vec++; if (pending !== 4'b0100) begin n_bad++; $display("FAIL prio_pend_left: got %b want 0100", pending); end
      on_interrupt = 2'b01; tick();
      on_interrupt = 2'b10; tick();
      on_interrupt = 2'b00; tick();
      n_vec++; if (irq_code !== 4'd0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL prio_gap: got code %0d busy %b want 0 0", irq_code, busy);
      end
      tick();
      n_vec++; if (irq_code !== 4'd3) begin n_bad++; $display("FAIL prio_second: got %0d want 3", irq_code); end
      on_interrupt = 2'b11; tick();
      on_interrupt = 2'b10; tick();
      on_interrupt = 2'b00; tick();
      keys_in = 4'b0000; tick(8);
      n_vec++; if (pending !== 4'd0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL prio_done: got pend %b busy %b want 0000 0", pending, busy);
      end
   endtask

   task automatic test_timeout();
      keys_in = 4'b0001; on_interrupt = 2'b00;
      tick(7);
      for (int i = 0; i < TMO; i++) begin
         n_vec++; if (irq_code !== 4'd1) begin n_bad++; $display("FAIL tmo_hold[%0d]: got %0d want 1", i, irq_code); end
         if (i < TMO - 1) tick();
      end
      tick();
      n_vec++; if (irq_code !== 4'd0) begin n_bad++; $display("FAIL tmo_gap_code: got %0d want 0", irq_code); end
      n_vec++; if (drop_count !== 8'd1) begin n_bad++; $display("FAIL tmo_drops: got %0d want 1", drop_count); end
      n_vec++; if (pending !== 4'b0001) begin n_bad++; $display("FAIL tmo_pend_kept: got %b want 0001", pending); end
      tick();
      n_vec++; if (irq_code !== 4'd1) begin n_bad++; $display("FAIL tmo_reissue: got %0d want 1", irq_code); end
      on_interrupt = 2'b11; tick();
      on_interrupt = 2'b00; tick();
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_abort_idle: got %b want 0", busy); end
      keys_in = 4'b0000; tick(8);
   endtask

   task automatic test_repress();
      keys_in = 4'b0001; tick(7);
      on_interrupt = 2'b11; tick();
      n_vec++; if (pending !== 4'd0) begin n_bad++; $display("FAIL repress_grant: got %b want 0000", pending); end
      on_interrupt = 2'b01;
      keys_in = 4'b0000; tick(8);
      keys_in = 4'b0001; tick(6);
      n_vec++; if (pending !== 4'b0001) begin n_bad++; $display("FAIL repress_pend: got %b want 0001", pending); end
      n_vec++; if (busy !== 1'b1 || irq_code !== 4'd0) begin
         n_bad++; $display("FAIL repress_in_service: got busy %b code %0d want 1 0", busy, irq_code);
      end
      on_interrupt = 2'b10; tick();
      on_interrupt = 2'b00; tick();
      n_vec++; if (irq_code !== 4'd0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL repress_gap: got code %0d busy %b want 0 0", irq_code, busy);
      end
      tick();
      n_vec++; if (irq_code !== 4'd1) begin n_bad++; $display("FAIL repress_reissue: got %0d want 1", irq_code); end
      on_interrupt = 2'b11; tick();
      on_interrupt = 2'b00; tick();
      keys_in = 4'b0000; tick(8);
   endtask

   task automatic test_reset_mid();
      keys_in = 4'b0100; tick(7);
      n_vec++; if (irq_code !== 4'd3) begin n_bad++; $display("FAIL rmid_code: got %0d want 3", irq_code); end
      on_interrupt = 2'b11; tick();
      on_interrupt = 2'b01;
      keys_in = 4'b0000; tick(8);
      keys_in = 4'b0100; tick(6);
      n_vec++; if (pending !== 4'b0100) begin n_bad++; $display("FAIL rmid_pend: got %b want 0100", pending); end
      reset = 1'b1; keys_in = 4'b0000; on_interrupt = 2'b00;
      tick();
      n_vec++; if (irq_code !== 0 || pending !== 0 || busy !== 0 || drop_count !== 0) begin
         n_bad++; $display("FAIL rmid_reset: got code %0d pend %b busy %b drops %0d want all 0",
                           irq_code, pending, busy, drop_count);
      end
      reset = 1'b0;
      tick(10);
      n_vec++; if (irq_code !== 4'd0 || pending !== 4'd0) begin
         n_bad++; $display("FAIL rmid_quiet: got code %0d pend %b want 0 0000", irq_code, pending);
      end
      keys_in = 4'b0100; tick(7);
      n_vec++; if (irq_code !== 4'd3) begin n_bad++; $display("FAIL rmid_new_press: got %0d want 3", irq_code); end
      on_interrupt = 2'b11; tick();
      on_interrupt = 2'b00; tick();
      keys_in = 4'b0000; tick(8);
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) keys_in = keys_in ^ (4'b0001 << $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) on_interrupt = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) irq_mask = 4'($urandom_range(0, 15));
         reset = ($urandom_range(0, 399) == 0);
         tick();
         n_vec++; if (irq_code !== m_code) begin n_bad++; $display("FAIL rnd_code @%0d: got %0d want %0d", i, irq_code, m_code); end
         n_vec++; if (pending !== m_pend) begin n_bad++; $display("FAIL rnd_pend @%0d: got %b want %b", i, pending, m_pend); end
         n_vec++; if (busy !== (m_phase != 0)) begin n_bad++; $display("FAIL rnd_busy @%0d: got %b want %b", i, busy, m_phase != 0); end
         n_vec++; if (drop_count !== 8'(m_drops)) begin n_bad++; $display("FAIL rnd_drops @%0d: got %0d want %0d", i, drop_count, m_drops); end
      end
      reset = 1'b0;
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_basic();
      test_glitch();
      test_priority();
      test_timeout();
      test_repress();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/irq_request_gen.md
Name: irq_request_gen

Overview:
- Source end of the button-interrupt protocol: conditions the four push-button lines and raises interrupt requests toward the interrupt controller that redirects the PC.
- Synchronizes and debounces each key, then latches rising edges as pending requests.
- Presents one code at a time on `irq_code`, and tracks the controller's `on_interrupt` status until the handler returns before issuing the next request.
- Sits between the board keys and the controller's `interruptSWInKey` input.

Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before a synchronized key level is accepted (≥2).
- `REQ_TIMEOUT`, 16: cycles a request is held unacknowledged before it is withdrawn (≥2).

Ports:
- `clock`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `keys_in`  in  4  raw asynchronous button levels, 1 = pressed
- `on_interrupt`  in  2  controller status: 00 idle, 11 entering, 01 in handler, 10 returning
- `irq_code`  out  4  request code to controller; 0 = no request
- `pending`  out  4  latched, not-yet-granted requests, bit k = key k
- `busy`  out  1  high in any state other than IDLE
- `drop_count`  out  8  saturating count of timed-out requests

Behaviour:
- Reset (synchronous, active-high): all outputs, synchronizers, debounced levels, debounce counters, state and timeout counter go to 0; state = IDLE.
  - Reset asserted mid-request or mid-service discards everything, including pending bits.
- Synchronizer: 2 flops per key.
- Debounce, per key:
  - Counter clears whenever sync == debounced.
  - Otherwise the counter increments; at count DEBOUNCE_CYCLES-1 with sync still differing, debounced <= sync and the counter clears.
  - A clean input step therefore reaches debounced 2+DEBOUNCE_CYCLES edges after it is sampled.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles is never accepted.
- Pending:
  - `pending[k]` is set on the same edge that debounced[k] rises 0→1. Falling edges do nothing.
  - A rise while `pending[k]` is already set is absorbed; there is no second request.
  - `pending[k]` clears on the edge the FSM leaves REQUEST for SERVICE while serving key k.
  - A rise of the key being serviced, arriving during SERVICE or RETURN, sets `pending[k]` again and is served after return.
  - If set and clear land on the same edge, set wins.
- Priority: lowest index wins. Code mapping: key0→1, key1→2, key2→3, key3→4.
- FSM states: IDLE, REQUEST, SERVICE, RETURN.
  - IDLE: if pending != 0, latch the winning index, load `irq_code` = index+1, clear the timeout counter, go to REQUEST. `irq_code` becomes valid in the first REQUEST cycle.
  - REQUEST: `irq_code` is held constant.
    - `on_interrupt` != 00 → go to SERVICE; `irq_code` <= 0; pending bit cleared.
    - Else, when the timeout counter reaches REQUEST_TIMEOUT-1 → go to IDLE; `irq_code` <= 0; `drop_count` += 1 (saturates at 255); pending bit kept, so the request is re-arbitrated next cycle.
  - SERVICE:
    - `on_interrupt` == 10 → go to RETURN.
    - `on_interrupt` == 00 (controller aborted) → go to IDLE.
    - 11 or 01 → stay.
  - RETURN: `on_interrupt` == 00 → go to IDLE; otherwise stay.
- Minimum gap between two requests: IDLE is entered for ≥1 cycle between them, with `irq_code` = 0 in that cycle.
- `busy` = (state != IDLE).

Optional Feature:
- Macro: `IRQ_MASK_EN`.
- When defined:
  - Adds input port `irq_mask`, 4 bits; bit k = 1 masks key k.
  - A masked key still debounces and still latches `pending[k]`, but is excluded from arbitration.
  - Unmasking makes it eligible the next cycle.
  - Masking a key already in REQUEST does not withdraw the request.
- When undefined: the port is absent and all keys are always eligible.

Test Plan (DEBOUNCE_CYCLES=4, REQ_TIMEOUT=8):
- Basic request:
  - Stimulus: reset 2 cycles, then hold `keys_in`=0001.
  - Response: `pending`=0001 after 6 edges; `irq_code`=1 one cycle later.
  - Then drive `on_interrupt`=11: next cycle `irq_code`=0 and `pending`=0.
  - Then drive 01, 10, 00: RETURN→IDLE, `busy`=0.
- Glitch reject: 3-cycle pulse on `keys_in[1]` → `pending` and `irq_code` stay 0.
- Priority:
  - Stimulus: keys 2 and 1 pressed simultaneously.
  - Response: `irq_code`=2 first; after the full handshake, `irq_code`=3 with ≥1 idle cycle between.
- Timeout:
  - Stimulus: key0 pressed, `on_interrupt` held 00.
  - Response: `irq_code`=1 for 8 cycles, then 0 for 1 cycle with `drop_count`=1, then `irq_code`=1 again.
- Re-press during service: key0 released and re-pressed while in SERVICE → `pending`=0001 set again; `irq_code`=1 reissued after the return to 00.
- Reset mid-service: assert `reset` in SERVICE with `pending`=0100 → next cycle all outputs 0; no request after release until a new press.
